// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned shift-and-add multiplier (IDLE -> RUN -> DONE); one adder, one bit per cycle.
// Optional macro SHIFT_ADD_MULT8_EARLY_TERM_EN finishes as soon as no set multiplier bits remain.

module bi8carryadder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[8];
endmodule

module shift_add_mult8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [7:0]  m_reg;
    logic [7:0]  q_reg;
    logic [7:0]  a_reg;
    logic [2:0]  count;
    logic [7:0]  add_b;
    logic [7:0]  sum;
    logic        c_bit;
    logic [7:0]  a_next;
    logic [7:0]  q_next;
    logic        last_iter;
    logic [15:0] result_next;

    assign add_b = q_reg[0] ? m_reg : 8'h00;

    bi8carryadder u_add (
        .a    (a_reg),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (c_bit)
    );

    // {C,A,Q} shifted right by one; the carry falls into the top of A
    assign a_next = {c_bit, sum[7:1]};
    assign q_next = {sum[0], q_reg[7:1]};

`ifdef SHIFT_ADD_MULT8_EARLY_TERM_EN
    logic [7:0] pending_mask;
    logic [2:0] remaining;

    // q_reg[7-count:1] still holds multiplier bits not yet processed
    assign pending_mask = (8'hFF >> count) & 8'hFE;
    assign remaining    = 3'd7 - count;
    assign last_iter    = (q_reg & pending_mask) == 8'h00;
    assign result_next  = {a_next, q_next} >> remaining;
`else
    assign last_iter   = (count == 3'd7);
    assign result_next = {a_next, q_next};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 16'h0000;
            m_reg   <= 8'h00;
            q_reg   <= 8'h00;
            a_reg   <= 8'h00;
            count   <= 3'd0;
        end else begin
            case (state)
                S_RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    count <= count + 3'd1;
                    if (last_iter) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= result_next;
                    end
                end
                default: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= 8'h00;
                        count <= 3'd0;
                        state <= S_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/shift_add_mult8.md
SHIFT_ADD_MULT8 -- requirements
Module: shift_add_mult8

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide: start  input  1  request a multiply; sampled on the rising edge.
REQ-004 SHALL provide: multiplicand  input  8  unsigned operand M; latched when start is accepted.
REQ-005 SHALL provide: multiplier  input  8  unsigned operand Q; latched when start is accepted.
REQ-006 SHALL provide: busy  output  1  high while an operation is in RUN.
REQ-007 SHALL provide: done  output  1  one-cycle pulse; product is valid.
REQ-008 SHALL provide: product  output  16  registered result; holds its value until the next completion.
REQ-009 SHALL perform every partial-sum addition with one instance of the existing bi8carryadder (A = accumulator, B = M or 0, Cin = 0); the carry-out is kept as bit C.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE; all outputs registered.
REQ-011 SHALL accept start in IDLE or DONE: on that edge latch M and Q, clear C:A (9 bits), clear iteration count, and go to RUN.
REQ-012 SHALL ignore start while in RUN; operands and progress are unaffected.
REQ-013 SHALL perform one iteration per RUN edge: if Q[0]=1 then {C,A} = A + M, else {C,A} = A; then {C,A,Q} shifts right by 1 with zero fill; count increments.
REQ-014 SHALL enter DONE on the 8th RUN edge; product = {A,Q} loads on that same edge.
REQ-015 SHALL make latency exactly 8 edges from start acceptance to DONE; done is high for the one cycle after the 8th iteration edge.
REQ-016 SHALL return from DONE to IDLE on the next edge if start=0, or to RUN (new operands) if start=1.
REQ-017 SHALL make busy = (state == RUN) and done = (state == DONE).
REQ-018 SHALL produce results exact modulo nothing: 8x8 unsigned into 16 bits, no overflow possible, for example 0xFF x 0xFF = 0xFE01.
REQ-019 SHALL ignore multiplicand and multiplier changes outside the accepting edge.

Reset
REQ-020 SHALL, on rst high, immediately force state = IDLE, busy = 0, done = 0, product = 0x0000, and clear C, A, Q, M and count, regardless of clk.
REQ-021 SHALL abort an in-flight operation on reset asserted mid-RUN: no done pulse, and product stays 0x0000.
REQ-022 SHALL ignore start while rst is high; the first acceptance is the first rising edge with rst low and start high.

Configuration
REQ-023 SHALL support macro SHIFT_ADD_MULT8_EARLY_TERM_EN.
- When defined: on any RUN edge where, after that iteration, all unprocessed multiplier bits are zero, jump to DONE with product = {C,A,Q} shifted right by the remaining iteration count (the final value equals the full result).
- Minimum latency is 1 edge. Multiplier 0x00 or 0x01 gives DONE after 1 edge; 0x80 still takes 8 edges.
REQ-024 SHALL, when the macro is undefined, always take exactly 8 iteration edges (REQ-015); results are identical in both builds.

Verification
REQ-025 SHALL cover: reset, then start with 0x0C x 0x0A -> done pulses once, 8 edges after acceptance; product = 0x0078; busy high for exactly 8 cycles.
REQ-026 SHALL cover: 0xFF x 0xFF -> product = 0xFE01 (carry path exercised); then 0x00 x 0xB7 -> product = 0x0000.
REQ-027 SHALL cover: start pulsed again at the 3rd RUN cycle with new operands 0x11 x 0x22 -> ignored; original product delivered; done pulses once.
REQ-028 SHALL cover: rst asserted asynchronously at the 5th RUN cycle -> busy and done drop immediately, product = 0x0000, and no done pulse follows.
REQ-029 SHALL cover: start held high in the DONE cycle with 0x03 x 0x05 -> the next operation begins without passing through IDLE; product = 0x000F.
REQ-030 SHALL cover, with SHIFT_ADD_MULT8_EARLY_TERM_EN defined: 0x9C x 0x01 -> done after 1 edge, product = 0x009C; 0x9C x 0x80 -> done after 8 edges, product = 0x4E00.
